// File: rtl/weather_pkg.sv
// ============================================================================
// Module  : weather_pkg
// Brief   : Shared month enumeration and month-length helper for the
//           month/weather sequencer and the downstream month FSM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package weather_pkg;

  typedef enum logic [2:0] {
    JANUARY  = 3'd0,
    FEBRUARY = 3'd1,
    MARCH    = 3'd2,
    APRIL    = 3'd3,
    MAY      = 3'd4,
    JUNE     = 3'd5,
    JULY     = 3'd6
  } month_t;

  localparam int TEMP_W_DEFAULT = 7;

  function automatic logic [4:0] month_len(month_t m, logic leap);
    logic [4:0] len;
    case (m)
      FEBRUARY:    len = leap ? 5'd29 : 5'd28;
      APRIL, JUNE: len = 5'd30;
      default:     len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/month_scheduler_ack_timer.sv
// ============================================================================
// Module  : ack_timer
// Brief   : Saturating acknowledge-wait counter; expire flags the cycle whose
//           closing edge completes ACK_TIMEOUT waiting cycles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (r_count != C_LAST) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expire = !clear && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/month_scheduler.sv
// ============================================================================
// Module  : month_scheduler
// Brief   : Day/month calendar sequencer with a month-boundary sensor
//           handshake, held samples and a one-cycle advance strobe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

import weather_pkg::*;

module month_scheduler #(
  parameter int TEMP_W      = TEMP_W_DEFAULT,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              day_tick,
  input  logic              leap_year,
  output logic              sample_req,
  input  logic              sample_ack,
  input  logic              snow_in,
  input  logic              rain_in,
  input  logic              cloud_in,
  input  logic [TEMP_W-1:0] temp_in,
  output logic              snow,
  output logic              rain,
  output logic              cloud,
  output logic [TEMP_W-1:0] temp,
  output logic              advance,
  output logic [2:0]        month,
  output logic [4:0]        day,
  output logic              timeout,
  output logic              tick_overrun
);

  typedef enum logic [1:0] {
    COUNT    = 2'd0,
    WAIT_ACK = 2'd1,
    ADVANCE  = 2'd2
  } ctrl_state_t;

  ctrl_state_t       r_state, w_state_next;
  month_t            r_month;
  logic [4:0]        r_day;
  logic              r_sample_req, r_advance;
  logic              r_snow, r_rain, r_cloud;
  logic [TEMP_W-1:0] r_temp;
  logic              r_timeout, r_tick_overrun;

  logic w_last_day, w_expire, w_capture, w_set_timeout;
  logic w_drop_tick, w_day_inc, w_roll;

  ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (r_state != WAIT_ACK),
    .expire  (w_expire)
  );

  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    w_set_timeout = 1'b0;
    w_drop_tick   = 1'b0;
    w_day_inc     = 1'b0;
    w_roll        = 1'b0;
    w_last_day    = (r_day == (month_len(r_month, leap_year) - 5'd1));
    case (r_state)
      COUNT: begin
        if (day_tick) begin
          if (w_last_day) w_state_next = WAIT_ACK;
          else            w_day_inc    = 1'b1;
        end
      end
      WAIT_ACK: begin
        w_drop_tick = day_tick;
        // An ack on the expiry cycle still wins over the timeout.
        if (sample_ack) begin
          w_capture    = 1'b1;
          w_state_next = ADVANCE;
        end else if (w_expire) begin
          w_set_timeout = 1'b1;
          w_state_next  = ADVANCE;
        end
      end
      ADVANCE: begin
        w_drop_tick  = day_tick;
        w_roll       = 1'b1;
        w_state_next = COUNT;
      end
      default: w_state_next = COUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= COUNT;
      r_month        <= JANUARY;
      r_day          <= 5'd0;
      r_sample_req   <= 1'b0;
      r_advance      <= 1'b0;
      r_snow         <= 1'b0;
      r_rain         <= 1'b0;
      r_cloud        <= 1'b0;
      r_temp         <= '0;
      r_timeout      <= 1'b0;
      r_tick_overrun <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_sample_req <= (w_state_next == WAIT_ACK);
      r_advance    <= (w_state_next == ADVANCE);
      if (w_day_inc) r_day <= r_day + 5'd1;
      if (w_roll) begin
        r_day   <= 5'd0;
        r_month <= (r_month == JULY) ? JANUARY : month_t'(r_month + 3'd1);
      end
      if (w_capture) begin
        r_snow  <= snow_in;
        r_rain  <= rain_in;
        r_cloud <= cloud_in;
        r_temp  <= temp_in;
      end
      if (w_set_timeout) r_timeout      <= 1'b1;
      if (w_drop_tick)   r_tick_overrun <= 1'b1;
    end
  end

  assign sample_req   = r_sample_req;
  assign advance      = r_advance;
  assign month        = r_month;
  assign day          = r_day;
  assign snow         = r_snow;
  assign rain         = r_rain;
  assign cloud        = r_cloud;
  assign temp         = r_temp;
  assign timeout      = r_timeout;
  assign tick_overrun = r_tick_overrun;

endmodule

`default_nettype wire

// File: tb/tb_month_scheduler.sv
// ============================================================================
// Module  : tb_month_scheduler
// Brief   : Randomised scoreboard bench for month_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_month_scheduler;

  localparam int TEMP_W = 7;
  localparam int T      = 15;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              day_tick = 1'b0;
  logic              leap_year = 1'b0;
  logic              sample_ack = 1'b0;
  logic              snow_in = 1'b0, rain_in = 1'b0, cloud_in = 1'b0;
  logic [TEMP_W-1:0] temp_in = '0;
  logic              sample_req, snow, rain, cloud, advance, timeout, tick_overrun;
  logic [TEMP_W-1:0] temp;
  logic [2:0]        month;
  logic [4:0]        day;

  month_scheduler #(
    .TEMP_W      (TEMP_W),
    .ACK_TIMEOUT (T)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .day_tick     (day_tick),
    .leap_year    (leap_year),
    .sample_req   (sample_req),
    .sample_ack   (sample_ack),
    .snow_in      (snow_in),
    .rain_in      (rain_in),
    .cloud_in     (cloud_in),
    .temp_in      (temp_in),
    .snow         (snow),
    .rain         (rain),
    .cloud        (cloud),
    .temp         (temp),
    .advance      (advance),
    .month        (month),
    .day          (day),
    .timeout      (timeout),
    .tick_overrun (tick_overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int month;
    int snow, rain, cloud, temp;
    int tmo, ovr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, passed = 0;

  // Reference calendar and held-sample model.
  int lens[7] = '{31, 28, 31, 30, 31, 30, 31};
  int m_month = 0, m_day = 0;
  int h_snow = 0, h_rain = 0, h_cloud = 0, h_temp = 0;
  int m_tmo = 0, m_ovr = 0;
  int feb_leap = 0;

  bit   mon_post = 1'b0;
  int   mon_next = 0;
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},     sample_req,   0);
    check({tag, "_adv"},     advance,      0);
    check({tag, "_month"},   month,        0);
    check({tag, "_day"},     day,          0);
    check({tag, "_snow"},    snow,         0);
    check({tag, "_rain"},    rain,         0);
    check({tag, "_cloud"},   cloud,        0);
    check({tag, "_temp"},    temp,         0);
    check({tag, "_timeout"}, timeout,      0);
    check({tag, "_overrun"}, tick_overrun, 0);
  endtask

  // Monitor: every advance strobe is matched against the next scoreboard entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (mon_post) begin
        check("post_month", month, mon_next);
        check("post_day", day, 0);
        check("adv_width", advance, 0);
        mon_post = 1'b0;
      end else if (advance) begin
        if (sb.size() == 0) begin
          check("unexpected_advance", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("adv_month",   month,        mon_e.month);
          check("adv_snow",    snow,         mon_e.snow);
          check("adv_rain",    rain,         mon_e.rain);
          check("adv_cloud",   cloud,        mon_e.cloud);
          check("adv_temp",    temp,         mon_e.temp);
          check("adv_timeout", timeout,      mon_e.tmo);
          check("adv_overrun", tick_overrun, mon_e.ovr);
          check("adv_req_low", sample_req,   0);
          mon_next = (mon_e.month + 1) % 7;
          mon_post = 1'b1;
        end
      end
    end
  end

  task automatic run_month(input int j, input bit drop, input bit rst_mid);
    int len;
    bit lp;
    bit acc;
    int s, r, c, tv;
    lp  = (m_month == 1) ? feb_leap[0] : 1'($urandom_range(0, 1));
    len = lens[m_month] + (((m_month == 1) && lp) ? 1 : 0);
    for (int t = 0; t < len; t++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 3) == 0) begin
          sample_ack = 1'b1;
          snow_in    = 1'($urandom_range(0, 1));
          temp_in    = TEMP_W'($urandom_range(0, 127));
        end
        @(negedge clock);
        sample_ack = 1'b0;
      end
      day_tick  = 1'b1;
      leap_year = lp;
      @(negedge clock);
      day_tick = 1'b0;
      if (t < len - 1) begin
        check("day_count", day, t + 1);
        check("req_idle", sample_req, 0);
      end else begin
        check("req_set", sample_req, 1);
        check("day_final", day, len - 1);
      end
      check("held_temp", temp, h_temp);
      check("held_snow", snow, h_snow);
    end

    if (rst_mid) begin
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("rst_mid");
      @(negedge clock);
      reset_n  = 1'b1;
      mon_post = 1'b0;
      m_month = 0; m_day = 0;
      h_snow = 0; h_rain = 0; h_cloud = 0; h_temp = 0;
      m_tmo = 0; m_ovr = 0;
      return;
    end

    acc = (j <= T);
    s  = $urandom_range(0, 1);
    r  = $urandom_range(0, 1);
    c  = $urandom_range(0, 1);
    tv = $urandom_range(0, 127);
    if (drop) m_ovr = 1;
    if (acc) begin
      h_snow = s; h_rain = r; h_cloud = c; h_temp = tv;
    end else begin
      m_tmo = 1;
    end
    sb.push_back('{m_month, h_snow, h_rain, h_cloud, h_temp, m_tmo, m_ovr});
    for (int k = 1; k <= j; k++) begin
      day_tick = drop && (k == 1);
      if (k == j) begin
        sample_ack = 1'b1;
        snow_in    = s[0];
        rain_in    = r[0];
        cloud_in   = c[0];
        temp_in    = TEMP_W'(tv);
      end
      @(negedge clock);
      day_tick   = 1'b0;
      sample_ack = 1'b0;
    end
    @(negedge clock);
    m_month = (m_month + 1) % 7;
    m_day   = 0;
    check("month_after", month, m_month);
    check("day_after", day, 0);
    check("req_after", sample_req, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int j;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    for (int mi = 0; mi < 21; mi++) begin
      case (mi % 4)
        0:       j = 1;
        1:       j = T;
        2:       j = T + 1;
        default: j = $urandom_range(1, T + 3);
      endcase
      feb_leap = (mi / 7) % 2;
      run_month(j, (mi % 3) == 1, 1'b0);
    end

    run_month(2, 1'b0, 1'b1);

    for (int t = 1; t <= 5; t++) begin
      day_tick = 1'b1;
      @(negedge clock);
      day_tick = 1'b0;
      check("restart_day", day, t);
      check("restart_month", month, 0);
      @(negedge clock);
    end

    repeat (3) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
